// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the SPI responder register file.
// Optional build macro: SPI_SLAVE_ERRCNT_EN (address 1 becomes an abort counter).
package spi_slave_pkg;

  localparam int         REG_ADDR_W    = 4;
  localparam logic [7:0] DEF_CMD_WRITE = 8'h0A;
  localparam logic [7:0] DEF_CMD_READ  = 8'h0B;
  localparam logic [7:0] DEF_DEVICE_ID = 8'hAD;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    IGNORE
  } state_e;

  // Conditioned SPI inputs as seen by the frame logic
  typedef struct packed {
    logic cs;         // synchronized chip select (1 = deasserted)
    logic mosi;       // synchronized MOSI
    logic sclk_rise;  // one-cycle strobe on synchronized spi_clk rise
    logic sclk_fall;  // one-cycle strobe on synchronized spi_clk fall
    logic cs_fall;    // frame start
    logic cs_rise;    // frame end
  } sync_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer for spi_clk, CS and MOSI plus edge strobes.
// Flops reset to the bus idle levels so no spurious edge follows reset.
module spi_slave_sync
  import spi_slave_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  spi_clk,
  input  logic  cs_n,
  input  logic  mosi,
  output sync_t sync_o
);

  // bit order: {spi_clk, cs_n, mosi}
  localparam logic [2:0] IDLE_LVL = 3'b110;

  logic [2:0] s1_q, s1_d;
  logic [2:0] s2_q, s2_d;
  logic [1:0] prev_q, prev_d;  // previous synchronized {spi_clk, cs_n}

  // next-state for synchronizer and edge-history flops
  always_comb begin
    s1_d   = {spi_clk, cs_n, mosi};
    s2_d   = s1_q;
    prev_d = s2_q[2:1];
  end

  // synchronizer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= IDLE_LVL;
      s2_q   <= IDLE_LVL;
      prev_q <= IDLE_LVL[2:1];
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  // edge detection on the synchronized copies
  always_comb begin
    sync_o.cs        = s2_q[1];
    sync_o.mosi      = s2_q[0];
    sync_o.sclk_rise =  s2_q[2] & ~prev_q[1];
    sync_o.sclk_fall = ~s2_q[2] &  prev_q[1];
    sync_o.cs_fall   = ~s2_q[1] &  prev_q[0];
    sync_o.cs_rise   =  s2_q[1] & ~prev_q[0];
  end

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-3 responder exposing a byte-addressed register file.
// Frame: command byte, address byte, data bytes with pointer auto-increment.
// Optional build macro: SPI_SLAVE_ERRCNT_EN turns address 1 into a read-only,
// read-to-clear, saturating counter of frames aborted mid-byte.
module spi_slave_regfile
  import spi_slave_pkg::*;
#(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] DEVICE_ID = DEF_DEVICE_ID,
  parameter logic [7:0] CMD_WRITE = DEF_CMD_WRITE,
  parameter logic [7:0] CMD_READ  = DEF_CMD_READ
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_clk,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic                  loc_wr_en,
  input  logic [REG_ADDR_W-1:0] loc_addr,
  input  logic [7:0]            loc_wdata,
  output logic                  spi_wr_stb,
  output logic [REG_ADDR_W-1:0] spi_wr_addr,
  output logic [7:0]            spi_wr_data,
  output logic                  busy
);

  localparam logic [8:0] NREGS     = 9'(NUM_REGS);
  localparam logic [7:0] LAST_ADDR = 8'(NUM_REGS - 1);

  function automatic logic in_range(input logic [7:0] a);
    return {1'b0, a} < NREGS;
  endfunction

  // address 0 is hard-wired; address 1 is hardware-owned with the counter
  function automatic logic wr_ok(input logic [7:0] a);
    logic ok;
    ok = in_range(a) && (a != 8'd0);
`ifdef SPI_SLAVE_ERRCNT_EN
    ok = ok && (a != 8'd1);
`endif
    return ok;
  endfunction

  function automatic logic [7:0] ptr_inc(input logic [7:0] a);
    return (a == LAST_ADDR) ? 8'd0 : a + 8'd1;
  endfunction

  sync_t sy;

  spi_slave_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .spi_clk(spi_clk),
    .cs_n   (CS),
    .mosi   (MOSI),
    .sync_o (sy)
  );

  state_e                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            shift_q, shift_d;
  logic [7:0]            tx_q, tx_d;
  logic [7:0]            ptr_q, ptr_d;
  logic                  wr_flag_q, wr_flag_d;
  logic                  miso_q, miso_d;
  logic                  stb_q, stb_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic [7:0]            regs_q [NUM_REGS];
  logic [7:0]            regs_d [NUM_REGS];

  logic [7:0] rx_byte;
  logic [7:0] rd_addr;
  logic [7:0] rd_val;
  logic       tx_load;
  logic       spi_we;
  logic       loc_ok;

`ifdef SPI_SLAVE_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;
`endif

  assign rx_byte = {shift_q, sy.mosi};
  assign loc_ok  = loc_wr_en && wr_ok({{(8 - REG_ADDR_W){1'b0}}, loc_addr});

  // address of the byte the tx register would load this cycle and its value
  always_comb begin
    rd_addr = (state_q == ADDR) ? rx_byte : ptr_inc(ptr_q);
    rd_val  = 8'h00;
    if (rd_addr == 8'd0) begin
      rd_val = DEVICE_ID;
    end else if (in_range(rd_addr)) begin
      rd_val = regs_q[rd_addr[REG_ADDR_W-1:0]];
`ifdef SPI_SLAVE_ERRCNT_EN
      if (rd_addr == 8'd1) rd_val = errcnt_q;
`endif
    end
  end

  // frame FSM: bit counting, byte decode, pointer, tx shifter, MISO and strobe
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    wr_flag_d = wr_flag_q;
    miso_d    = miso_q;
    stb_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    tx_load   = 1'b0;
    spi_we    = 1'b0;
    if (sy.cs) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
      if (sy.cs_rise) shift_d = 7'd0;  // flush any partial byte
    end else if (state_q == IDLE) begin
      if (sy.cs_fall) begin
        state_d   = CMD;
        bit_cnt_d = 3'd0;
      end
    end else begin
      if (sy.sclk_rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = rx_byte[6:0];
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            CMD: begin
              if (rx_byte == CMD_WRITE) begin
                state_d   = ADDR;
                wr_flag_d = 1'b1;
              end else if (rx_byte == CMD_READ) begin
                state_d   = ADDR;
                wr_flag_d = 1'b0;
              end else begin
                state_d = IGNORE;
              end
            end
            ADDR: begin
              ptr_d = rx_byte;
              if (wr_flag_q) begin
                state_d = WDATA;
              end else begin
                state_d = RDATA;
                tx_d    = rd_val;
                tx_load = 1'b1;
              end
            end
            WDATA: begin
              if (wr_ok(ptr_q)) begin
                spi_we    = 1'b1;
                stb_d     = 1'b1;
                wr_addr_d = ptr_q[REG_ADDR_W-1:0];
                wr_data_d = rx_byte;
              end
              ptr_d = ptr_inc(ptr_q);
            end
            RDATA: begin
              ptr_d   = ptr_inc(ptr_q);
              tx_d    = rd_val;
              tx_load = 1'b1;
            end
            default: ;
          endcase
        end
      end
      if (sy.sclk_fall) begin
        if (state_q == RDATA) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end else begin
          miso_d = 1'b0;
        end
      end
    end
  end

  // frame FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      tx_q      <= 8'd0;
      ptr_q     <= 8'd0;
      wr_flag_q <= 1'b0;
      miso_q    <= 1'b0;
      stb_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      wr_flag_q <= wr_flag_d;
      miso_q    <= miso_d;
      stb_q     <= stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // register file update: local write first so a same-address SPI commit wins
  always_comb begin
    regs_d = regs_q;
    if (loc_ok) regs_d[loc_addr] = loc_wdata;
    if (spi_we) regs_d[ptr_q[REG_ADDR_W-1:0]] = rx_byte;
  end

  // register file storage (entry 0 stays 0; reads of address 0 return DEVICE_ID)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'd0;
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef SPI_SLAVE_ERRCNT_EN
  // abort counter: clear when handed to the tx register, saturating count
  always_comb begin
    errcnt_d = errcnt_q;
    if (tx_load && (rd_addr == 8'd1)) begin
      errcnt_d = 8'd0;
    end else if (sy.cs_rise && (bit_cnt_q != 3'd0) && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  // abort counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) errcnt_q <= 8'd0;
    else     errcnt_q <= errcnt_d;
  end
`endif

  assign MISO        = miso_q;
  assign spi_wr_stb  = stb_q;
  assign spi_wr_addr = wr_addr_q;
  assign spi_wr_data = wr_data_q;
  assign busy        = ~sy.cs;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboard bench for spi_slave_regfile: a bus-level SPI master drives frames,
// an abstract register model predicts strobes and read bytes, and independent
// monitors on the strobe port and the SPI pins pop and compare.
module tb_spi_slave_regfile;
  import spi_slave_pkg::*;

  localparam int         NREG = 16;
  localparam logic [7:0] DID  = 8'hAD;
  localparam logic [7:0] CW   = 8'h0A;
  localparam logic [7:0] CR   = 8'h0B;

  logic       clk = 1'b0, rst = 1'b1;
  logic       spi_clk = 1'b1, CS = 1'b1, MOSI = 1'b0;
  logic       loc_wr_en = 1'b0;
  logic [3:0] loc_addr = 4'd0;
  logic [7:0] loc_wdata = 8'd0;
  logic       MISO, spi_wr_stb, busy;
  logic [3:0] spi_wr_addr;
  logic [7:0] spi_wr_data;

  always #5 clk = ~clk;

  spi_slave_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .CS         (CS),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .loc_wr_en  (loc_wr_en),
    .loc_addr   (loc_addr),
    .loc_wdata  (loc_wdata),
    .spi_wr_stb (spi_wr_stb),
    .spi_wr_addr(spi_wr_addr),
    .spi_wr_data(spi_wr_data),
    .busy       (busy)
  );

  int nchk = 0, nerr = 0;

  typedef struct {logic [3:0] a; logic [7:0] d;} stb_t;
  stb_t       exp_stb[$];
  logic [7:0] exp_rd[$];
  stb_t       mon_e;

  // ---------------- reference model ----------------
  logic [7:0] m_regs [NREG];
  logic [7:0] m_err;

  function automatic void m_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'd0;
    m_err = 8'd0;
  endfunction

  function automatic bit m_wr_ok(int a);
    bit ok;
    ok = (a > 0) && (a < NREG);
`ifdef SPI_SLAVE_ERRCNT_EN
    ok = ok && (a != 1);
`endif
    return ok;
  endfunction

  function automatic int m_next(int a);
    return (a == NREG - 1) ? 0 : (a + 1) % 256;
  endfunction

  function automatic logic [7:0] m_load(int a);
    logic [7:0] v;
    if (a == 0) return DID;
    if (a >= NREG) return 8'h00;
`ifdef SPI_SLAVE_ERRCNT_EN
    if (a == 1) begin
      v = m_err;
      m_err = 8'd0;
      return v;
    end
`endif
    v = m_regs[a];
    return v;
  endfunction

  function automatic void m_local(int a, logic [7:0] d);
    if (m_wr_ok(a)) m_regs[a] = d;
  endfunction

  // predict one frame: full bytes in bq, tail partial bits after them
  function automatic void m_frame(logic [7:0] bq[$], int tail, bit loc, int la, logic [7:0] ld);
    int p, n;
    logic [7:0] v;
    stb_t s;
    n = bq.size();
    if (n >= 2 && bq[0] == CW) begin
      p = bq[1];
      for (int i = 2; i < n; i++) begin
        if (loc && i == n - 1) m_local(la, ld);
        if (m_wr_ok(p)) begin
          m_regs[p] = bq[i];
          s.a = p[3:0];
          s.d = bq[i];
          exp_stb.push_back(s);
        end
        p = m_next(p);
      end
    end else if (n >= 2 && bq[0] == CR) begin
      // one load per completed byte from the address byte onward
      p = bq[1];
      for (int i = 2; i <= n; i++) begin
        v = m_load(p);
        if (i < n) exp_rd.push_back(v);
        p = m_next(p);
      end
    end
    if (tail != 0 && m_err != 8'hFF) m_err = m_err + 8'd1;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // strobe monitor
  always @(negedge clk) begin
    if (!rst && spi_wr_stb) begin
      if (exp_stb.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_stb: got addr %0h data %0h expected no strobe", spi_wr_addr, spi_wr_data);
      end else begin
        mon_e = exp_stb.pop_front();
        chk("stb_addr", {28'd0, spi_wr_addr}, {28'd0, mon_e.a});
        chk("stb_data", {24'd0, spi_wr_data}, {24'd0, mon_e.d});
      end
    end
  end

  // SPI pin monitor: decodes frames as the master sees them
  initial begin : frame_mon
    int bits;
    logic [7:0] rxb, txb, cmd;
    forever begin
      @(negedge CS);
      bits = 0;
      cmd  = 8'd0;
      rxb  = 8'd0;
      txb  = 8'd0;
      forever begin
        @(posedge spi_clk or posedge CS);
        if (CS) break;
        rxb = {rxb[6:0], MOSI};
        txb = {txb[6:0], MISO};
        bits++;
        if (bits % 8 == 0) begin
          if (bits == 8) cmd = rxb;
          if (cmd == CR && bits >= 24) begin
            if (exp_rd.size() == 0) begin
              nchk++;
              nerr++;
              $display("FAIL unexpected_rd: got %0h expected no read byte", txb);
            end else begin
              chk("miso_rd", {24'd0, txb}, {24'd0, exp_rd.pop_front()});
            end
          end else begin
            chk("miso_quiet", {24'd0, txb}, 32'd0);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // shift nb bits MSB first; entered and left on a clk negedge
  task automatic xfer(input logic [7:0] b, input int nb, input bit loc,
                      input logic [3:0] la, input logic [7:0] ld);
    for (int i = 0; i < nb; i++) begin
      spi_clk = 1'b0;
      MOSI    = b[7-i];
      wait_clk(5);
      spi_clk = 1'b1;
      if (loc && i == nb - 1) begin
        // land a local write on the clk edge that commits this SPI byte
        @(posedge clk);
        @(posedge clk);
        #1;
        loc_addr  = la;
        loc_wdata = ld;
        loc_wr_en = 1'b1;
        @(posedge clk);
        #1 loc_wr_en = 1'b0;
        wait_clk(4);
      end else begin
        wait_clk(5);
      end
    end
  endtask

  task automatic frame(input logic [7:0] bq[$], input int tail = 0, input logic [7:0] tb8 = 8'h00,
                       input bit loc = 1'b0, input logic [3:0] la = 4'd0, input logic [7:0] ld = 8'd0);
    m_frame(bq, tail, loc, int'(la), ld);
    @(negedge clk);
    CS = 1'b0;
    wait_clk(4);
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < bq.size(); i++) xfer(bq[i], 8, loc && (i == bq.size() - 1), la, ld);
    if (tail > 0) xfer(tb8, tail, 1'b0, 4'd0, 8'd0);
    wait_clk(4);
    CS = 1'b1;
    wait_clk(6);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic loc_write(input int a, input logic [7:0] d);
    @(negedge clk);
    loc_addr  = a[3:0];
    loc_wdata = d;
    loc_wr_en = 1'b1;
    @(negedge clk);
    loc_wr_en = 1'b0;
    m_local(a, d);
  endtask

  function automatic logic [7:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return 8'($urandom_range(16, 255));
    return 8'($urandom_range(0, 15));
  endfunction

  initial begin
    logic [7:0] q[$];
    int op, n, tail;
    logic [7:0] c;

    m_reset();
    wait_clk(3);
    chk("rst_miso", {31'd0, MISO}, 32'd0);
    chk("rst_stb", {31'd0, spi_wr_stb}, 32'd0);
    chk("rst_wr_addr", {28'd0, spi_wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, spi_wr_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    wait_clk(5);

    // device ID
    frame('{CR, 8'h00, 8'h5A});
    // burst write and read-back
    frame('{CW, 8'h03, 8'h11, 8'h22});
    frame('{CR, 8'h03, 8'h00, 8'h00});
    // wrap across the top of the map
    loc_write(15, 8'hC3);
    loc_write(1, 8'h3C);
    frame('{CR, 8'h0F, 8'hFF, 8'hFF, 8'hFF});
    // out-of-range and read-only addresses
    frame('{CW, 8'h20, 8'h77});
    frame('{CR, 8'h20, 8'h00});
    frame('{CW, 8'h00, 8'h12});
    frame('{CR, 8'h00, 8'h00});
    // abort mid data byte
    frame('{CW, 8'h05, 8'h66});
    frame('{CW, 8'h05}, 5, 8'hF0);
    frame('{CR, 8'h05, 8'h00});
    frame('{CR, 8'h01, 8'h00});
    frame('{CR, 8'h01, 8'h00});
    // commit collisions with the local port
    frame('{CW, 8'h06, 8'h99}, 0, 8'h00, 1'b1, 4'd6, 8'h55);
    frame('{CW, 8'h08, 8'h77}, 0, 8'h00, 1'b1, 4'd9, 8'h44);
    frame('{CR, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00});
    // unknown command
    frame('{8'h0C, 8'h0B, 8'h03, 8'hFF});
    // local write to the byte in flight
    q = '{CR, 8'h04, 8'h00};
    fork
      frame(q);
      begin
        wait_clk(200);
        loc_write(4, 8'h5E);
      end
    join
    frame('{CR, 8'h04, 8'h00});

    // randomized traffic
    for (int it = 0; it < 25; it++) begin
      op = $urandom_range(0, 4);
      q  = {};
      tail = 0;
      case (op)
        0: loc_write($urandom_range(0, 15), 8'($urandom));
        1, 2: begin
          q.push_back(CW);
          q.push_back(rnd_addr());
          n = $urandom_range(1, 3);
          for (int k = 0; k < n; k++) q.push_back(8'($urandom));
          if ($urandom_range(0, 5) == 0) tail = $urandom_range(1, 7);
          frame(q, tail, 8'($urandom));
        end
        3: begin
          q.push_back(CR);
          q.push_back(rnd_addr());
          n = $urandom_range(1, 4);
          for (int k = 0; k < n; k++) q.push_back(8'($urandom));
          frame(q);
        end
        default: begin
          c = 8'($urandom);
          if (c == CW || c == CR) c = 8'h5C;
          q.push_back(c);
          n = $urandom_range(1, 3);
          for (int k = 0; k < n; k++) q.push_back(8'($urandom));
          frame(q);
        end
      endcase
    end

    // reset in the middle of a read data byte
    loc_write(10, 8'hE5);
    @(negedge clk);
    CS = 1'b0;
    wait_clk(4);
    xfer(CR, 8, 1'b0, 4'd0, 8'd0);
    xfer(8'h0A, 8, 1'b0, 4'd0, 8'd0);
    xfer(8'hFF, 3, 1'b0, 4'd0, 8'd0);
    chk("miso_pre_rst", {31'd0, MISO}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_miso", {31'd0, MISO}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
    wait_clk(2);
    CS = 1'b1;
    m_reset();
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    frame('{CR, 8'h0A, 8'h00});
    frame('{CR, 8'h03, 8'h00});

    wait_clk(20);
    chk("stb_queue_empty", exp_stb.size(), 32'd0);
    chk("rd_queue_empty", exp_rd.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
